// File: rtl/piece_bag_generator.sv
// 7-bag tetromino dealer. A free-running LFSR picks a start slot, and a circular
// scan of the remaining-shape mask yields the next shape not yet dealt in this bag.
module piece_bag_generator #(
   parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_start,
   input  logic       i_spawn_req,
   output logic       o_ready,
   output logic [2:0] o_cur_shape,
   output logic [2:0] o_next_shape,
   output logic [2:0] o_bag_left,
   output logic [1:0] dbg_state
);

   // An all-zero Galois LFSR would lock up, so a zero seed is promoted to 1.
   localparam logic [15:0] SEED_EFF = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      SCAN  = 2'd2,
      READY = 2'd3
   } state_t;

   typedef enum logic {
      DEST_CUR  = 1'b0,
      DEST_NEXT = 1'b1
   } dest_t;

   state_t      state;
   dest_t       dest;
   logic [15:0] lfsr;
   logic [6:0]  mask;
   logic [2:0]  idx;
   logic [15:0] lfsr_step;
   logic [6:0]  mask_taken;

   assign lfsr_step  = lfsr[0] ? ((lfsr >> 1) ^ 16'hB400) : (lfsr >> 1);
   assign mask_taken = mask & ~(7'b1 << idx);
   assign dbg_state  = state;

   always_comb begin
      o_bag_left = 3'd0;
      for (int i = 0; i < 7; i++) begin
         o_bag_left = o_bag_left + {2'b00, mask[i]};
      end
   end

   // Handshake: i_spawn_req is a single-cycle request honoured only on an edge
   // where o_ready is high; requests while o_ready is low are dropped, not queued.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state        <= IDLE;
         dest         <= DEST_CUR;
         lfsr         <= SEED_EFF;
         mask         <= 7'h7F;
         idx          <= 3'd0;
         o_ready      <= 1'b0;
         o_cur_shape  <= 3'd7;
         o_next_shape <= 3'd7;
      end else begin
         lfsr <= lfsr_step;
         if (i_start && (state != IDLE)) begin
            // Game restart: fresh bag, blank pieces; the LFSR keeps running.
            mask         <= 7'h7F;
            o_cur_shape  <= 3'd7;
            o_next_shape <= 3'd7;
            o_ready      <= 1'b0;
            dest         <= DEST_CUR;
            state        <= LOAD;
         end else begin
            case (state)
               IDLE: begin
                  if (i_start) begin
                     dest  <= DEST_CUR;
                     state <= LOAD;
                  end
               end
               LOAD: begin
                  idx   <= (lfsr[2:0] == 3'd7) ? 3'd0 : lfsr[2:0];
                  state <= SCAN;
               end
               SCAN: begin
                  if (mask[idx]) begin
                     if (dest == DEST_CUR) begin
                        o_cur_shape <= idx;
                     end else begin
                        o_next_shape <= idx;
                     end
                     // Emptying the bag refills it in the same cycle, so SCAN never sees 0.
                     mask <= (mask_taken == 7'h00) ? 7'h7F : mask_taken;
                     if (dest == DEST_CUR) begin
                        dest  <= DEST_NEXT;
                        state <= LOAD;
                     end else begin
                        o_ready <= 1'b1;
                        state   <= READY;
                     end
                  end else begin
                     idx <= (idx == 3'd6) ? 3'd0 : idx + 3'd1;
                  end
               end
               READY: begin
                  if (i_spawn_req) begin
                     o_cur_shape <= o_next_shape;
                     o_ready     <= 1'b0;
                     dest        <= DEST_NEXT;
                     state       <= LOAD;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_piece_bag_generator.sv
// Directed bench for piece_bag_generator: reset, dealing, 7-bag property,
// spawn timing, restarts, mid-draw reset and a zero-seed instance.
module tb_piece_bag_generator;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_LOAD = 2'd1;
   localparam logic [1:0] S_SCAN = 2'd2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n, start, spawn, z_start, z_spawn;
   logic       ready, z_ready;
   logic [2:0] cur, nxt, bag, z_cur, z_nxt, z_bag;
   logic [1:0] st, z_st;

   int checks = 0;
   int passes = 0;

   logic [2:0]  load_q[$];
   logic [2:0]  z_load_q[$];
   logic [15:0] m_lfsr, z_lfsr;

   piece_bag_generator dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_spawn_req(spawn),
      .o_ready(ready), .o_cur_shape(cur), .o_next_shape(nxt), .o_bag_left(bag),
      .dbg_state(st)
   );

   piece_bag_generator #(.LFSR_SEED(16'h0000)) dut_zero (
      .i_clk(clk), .i_rst_n(rst_n), .i_start(z_start), .i_spawn_req(z_spawn),
      .o_ready(z_ready), .o_cur_shape(z_cur), .o_next_shape(z_nxt), .o_bag_left(z_bag),
      .dbg_state(z_st)
   );

   function automatic logic [15:0] lfsr_adv(input logic [15:0] v);
      return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
   endfunction

   function automatic logic [2:0] slot(input logic [15:0] v);
      return (v[2:0] == 3'd7) ? 3'd0 : v[2:0];
   endfunction

   function automatic logic [2:0] scan(input logic [2:0] s, input logic [6:0] m);
      logic [2:0] i;
      i = s;
      for (int k = 0; k < 7; k++) begin
         if (m[i]) return i;
         i = (i == 3'd6) ? 3'd0 : i + 3'd1;
      end
      return 3'd7;
   endfunction

   function automatic logic [6:0] take(input logic [6:0] m, input logic [2:0] s);
      logic [6:0] r;
      r = m & ~(7'b1 << s);
      return (r == 7'h00) ? 7'h7F : r;
   endfunction

   // Reference LFSRs follow the polynomial from reset; each LOAD cycle records
   // the start slot the draw will scan from.
   always @(posedge clk) begin
      m_lfsr <= rst_n ? lfsr_adv(m_lfsr) : 16'hACE1;
      z_lfsr <= rst_n ? lfsr_adv(z_lfsr) : 16'h0001;
   end

   always @(negedge clk) begin
      if (rst_n === 1'b1 && st == S_LOAD) load_q.push_back(slot(m_lfsr));
      if (rst_n === 1'b1 && z_st == S_LOAD) z_load_q.push_back(slot(z_lfsr));
   end

   task automatic wait_ready(input int max, output int n);
      n = 0;
      while (ready !== 1'b1 && n < max) begin
         @(negedge clk);
         n++;
      end
   endtask

   task automatic pulse_start();
      start = 1'b1;
      load_q.delete();
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start = 1'b1; spawn = 1'b0; z_start = 1'b0; z_spawn = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         checks++;
         if ({ready, cur, nxt, bag} !== {1'b0, 3'd7, 3'd7, 3'd7})
            $display("FAIL reset_outputs: got rdy=%0d cur=%0d nxt=%0d bag=%0d expected 0/7/7/7", ready, cur, nxt, bag);
         else passes++;
      end
      rst_n = 1'b1; start = 1'b0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         checks++;
         if ({st, ready, cur, nxt} !== {S_IDLE, 1'b0, 3'd7, 3'd7})
            $display("FAIL idle_hold: got st=%0d rdy=%0d cur=%0d nxt=%0d expected 0/0/7/7", st, ready, cur, nxt);
         else passes++;
      end
   endtask

   task automatic test_start();
      int n;
      logic [6:0] mm;
      logic [2:0] e0, e1;
      pulse_start();
      wait_ready(16, n);
      checks++;
      if (ready !== 1'b1) $display("FAIL start_ready: got %0d after %0d cycles expected 1", ready, n);
      else passes++;
      checks++;
      if (!(cur < 3'd7 && nxt < 3'd7 && cur != nxt))
         $display("FAIL start_pair: got cur=%0d nxt=%0d expected distinct 0..6", cur, nxt);
      else passes++;
      checks++;
      if (bag !== 3'd5) $display("FAIL start_bag: got %0d expected 5", bag);
      else passes++;
      checks++;
      if (load_q.size() !== 2) $display("FAIL start_loads: got %0d expected 2", load_q.size());
      else passes++;
      if (load_q.size() >= 2) begin
         mm = 7'h7F;
         e0 = scan(load_q[0], mm);
         mm = take(mm, e0);
         e1 = scan(load_q[1], mm);
         checks++;
         if (cur !== e0) $display("FAIL start_cur_model: got %0d expected %0d", cur, e0);
         else passes++;
         checks++;
         if (nxt !== e1) $display("FAIL start_next_model: got %0d expected %0d", nxt, e1);
         else passes++;
      end
   endtask

   task automatic test_bag();
      int n, r;
      logic [6:0] mm;
      logic [7:0] seen;
      logic [2:0] e;
      logic [2:0] dealt[$];
      pulse_start();
      wait_ready(16, n);
      mm = 7'h7F;
      for (int p = 0; p < 2; p++) begin
         e = (load_q.size() > 0) ? scan(load_q.pop_front(), mm) : 3'd7;
         mm = take(mm, e);
         checks++;
         if (((p == 0) ? cur : nxt) !== e)
            $display("FAIL bag_pair_model: slot %0d got %0d expected %0d", p, (p == 0) ? cur : nxt, e);
         else passes++;
      end
      dealt.push_back(cur);
      dealt.push_back(nxt);
      for (int k = 1; k <= 12; k++) begin
         load_q.delete();
         spawn = 1'b1;
         @(negedge clk);
         spawn = 1'b0;
         wait_ready(16, n);
         checks++;
         if (ready !== 1'b1) $display("FAIL bag_ready: spawn %0d got %0d expected 1", k, ready);
         else passes++;
         checks++;
         if (load_q.size() !== 1) $display("FAIL bag_loads: spawn %0d got %0d expected 1", k, load_q.size());
         else passes++;
         e = (load_q.size() > 0) ? scan(load_q.pop_front(), mm) : 3'd7;
         mm = take(mm, e);
         checks++;
         if (nxt !== e) $display("FAIL bag_next_model: spawn %0d got %0d expected %0d", k, nxt, e);
         else passes++;
         dealt.push_back(nxt);
         r = (2 + k) % 7;
         checks++;
         if (bag !== 3'((r == 0) ? 7 : 7 - r))
            $display("FAIL bag_left: spawn %0d got %0d expected %0d", k, bag, (r == 0) ? 7 : 7 - r);
         else passes++;
      end
      checks++;
      if (dealt.size() !== 14) $display("FAIL bag_count: got %0d expected 14", dealt.size());
      else passes++;
      for (int g = 0; g < 2; g++) begin
         seen = 8'h00;
         for (int i = 0; i < 7; i++) seen = seen | (8'd1 << dealt[g * 7 + i]);
         checks++;
         if (seen !== 8'h7F) $display("FAIL bag_perm: group %0d got %h expected 7f", g, seen);
         else passes++;
      end
   endtask

   task automatic test_spawn_timing();
      int n;
      logic [2:0] prev;
      for (int k = 0; k < 3; k++) begin
         prev = nxt;
         spawn = 1'b1;
         @(negedge clk);
         if (k != 1) spawn = 1'b0;
         checks++;
         if (cur !== prev) $display("FAIL spawn_cur: got %0d expected %0d", cur, prev);
         else passes++;
         checks++;
         if (ready !== 1'b0) $display("FAIL spawn_ready_t1: got %0d expected 0", ready);
         else passes++;
         @(negedge clk);
         spawn = 1'b0;
         checks++;
         if (ready !== 1'b0) $display("FAIL spawn_ready_t2: got %0d expected 0", ready);
         else passes++;
         wait_ready(7, n);
         checks++;
         if (ready !== 1'b1) $display("FAIL spawn_ready_max: got %0d expected 1", ready);
         else passes++;
         checks++;
         if (bag !== 3'(6 - k)) $display("FAIL spawn_bag_dec: got %0d expected %0d", bag, 6 - k);
         else passes++;
         checks++;
         if (cur !== prev) $display("FAIL spawn_cur_hold: got %0d expected %0d", cur, prev);
         else passes++;
      end
   endtask

   task automatic test_restart_ready();
      int n;
      pulse_start();
      checks++;
      if ({ready, cur, nxt} !== {1'b0, 3'd7, 3'd7})
         $display("FAIL rr_blank: got rdy=%0d cur=%0d nxt=%0d expected 0/7/7", ready, cur, nxt);
      else passes++;
      wait_ready(16, n);
      checks++;
      if (ready !== 1'b1 || bag !== 3'd5 || cur >= 3'd7 || nxt >= 3'd7 || cur == nxt)
         $display("FAIL rr_fresh: got rdy=%0d bag=%0d cur=%0d nxt=%0d expected 1/5/distinct", ready, bag, cur, nxt);
      else passes++;
   endtask

   task automatic test_restart_scan();
      int n;
      logic [7:0] seen;
      spawn = 1'b1;
      @(negedge clk);
      spawn = 1'b0;
      @(negedge clk);
      checks++;
      if (st !== S_SCAN) $display("FAIL rs_in_scan: got %0d expected %0d", st, S_SCAN);
      else passes++;
      pulse_start();
      checks++;
      if ({ready, cur, nxt} !== {1'b0, 3'd7, 3'd7})
         $display("FAIL rs_blank: got rdy=%0d cur=%0d nxt=%0d expected 0/7/7", ready, cur, nxt);
      else passes++;
      wait_ready(16, n);
      checks++;
      if (ready !== 1'b1 || bag !== 3'd5)
         $display("FAIL rs_fresh: got rdy=%0d bag=%0d expected 1/5", ready, bag);
      else passes++;
      seen = (8'd1 << cur) | (8'd1 << nxt);
      for (int k = 0; k < 5; k++) begin
         spawn = 1'b1;
         @(negedge clk);
         spawn = 1'b0;
         wait_ready(16, n);
         seen = seen | (8'd1 << nxt);
      end
      checks++;
      if (seen !== 8'h7F) $display("FAIL rs_fresh_bag: got %h expected 7f", seen);
      else passes++;
   endtask

   task automatic test_reset_mid_scan();
      spawn = 1'b1;
      @(negedge clk);
      spawn = 1'b0;
      @(negedge clk);
      checks++;
      if (st !== S_SCAN) $display("FAIL rm_in_scan: got %0d expected %0d", st, S_SCAN);
      else passes++;
      rst_n = 1'b0;
      @(negedge clk);
      checks++;
      if ({st, ready, cur, nxt, bag} !== {S_IDLE, 1'b0, 3'd7, 3'd7, 3'd7})
         $display("FAIL rm_outputs: got st=%0d rdy=%0d cur=%0d nxt=%0d bag=%0d expected 0/0/7/7/7", st, ready, cur, nxt, bag);
      else passes++;
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if ({st, ready} !== {S_IDLE, 1'b0}) $display("FAIL rm_idle: got st=%0d rdy=%0d expected 0/0", st, ready);
      else passes++;
   endtask

   task automatic test_seed_zero();
      int n;
      logic [6:0] mm;
      logic [2:0] e0, e1;
      z_start = 1'b1;
      z_load_q.delete();
      @(negedge clk);
      z_start = 1'b0;
      n = 0;
      while (z_ready !== 1'b1 && n < 16) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (z_ready !== 1'b1 || z_bag !== 3'd5) $display("FAIL zero_ready: got rdy=%0d bag=%0d expected 1/5", z_ready, z_bag);
      else passes++;
      checks++;
      if (z_load_q.size() !== 2) $display("FAIL zero_loads: got %0d expected 2", z_load_q.size());
      else passes++;
      if (z_load_q.size() >= 2) begin
         mm = 7'h7F;
         e0 = scan(z_load_q[0], mm);
         mm = take(mm, e0);
         e1 = scan(z_load_q[1], mm);
         checks++;
         if ({z_cur, z_nxt} !== {e0, e1})
            $display("FAIL zero_pair_model: got %0d/%0d expected %0d/%0d", z_cur, z_nxt, e0, e1);
         else passes++;
      end
   endtask

   initial begin
      test_reset();
      test_start();
      test_bag();
      test_spawn_timing();
      test_restart_ready();
      test_restart_scan();
      test_reset_mid_scan();
      test_seed_zero();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/piece_bag_generator.md
Name: piece_bag_generator

Overview:
- Sequential piece source for the game core.
- Deals tetromino shape codes 0..6 using a "7-bag" randomiser: every 7 consecutive dealt pieces form a permutation of all 7 shapes.
- Holds the current piece, which feeds the shape decoder and colour decoder at spawn, and the preview piece, which feeds the next-piece display box.
- Randomness comes from a free-running LFSR, so player timing perturbs the sequence.

Parameters:
LFSR_SEED, 16'hACE1, LFSR reset value; a value of 0 is replaced by 16'h0001.

Ports:
i_clk  input  1  system clock
i_rst_n  input  1  reset; one clock; synchronous, active-low
i_start  input  1  pulse; begin/restart dealing with a fresh bag
i_spawn_req  input  1  pulse; consume current piece, promote preview, draw new preview
o_ready  output  1  high when cur/next are valid and a spawn request will be accepted
o_cur_shape  output  3  shape of piece to spawn (0..6; 7 = none)
o_next_shape  output  3  preview shape (0..6; 7 = none, displays blank)
o_bag_left  output  3  number of shapes still in the current bag (popcount of mask, 0..7)

Behaviour:
- Reset values (i_rst_n low at clock edge): state IDLE, o_ready=0, o_cur_shape=7, o_next_shape=7, mask=7'h7F, o_bag_left=7, lfsr=LFSR_SEED (or 1 if LFSR_SEED is 0), idx=0, dest=CUR. Reset wins over all other inputs.
- LFSR: 16-bit Galois, polynomial x^16+x^14+x^13+x^11+1 (shift right, XOR 16'hB400 when lsb=1). Advances every cycle in every state except reset.
- mask[6:0]: bit s set means shape s has not yet been dealt from the current bag.
- States:
  - IDLE: o_ready=0. On i_start: dest<=CUR, goto LOAD.
  - LOAD (1 cycle): idx <= (lfsr[2:0]==7) ? 0 : lfsr[2:0]; goto SCAN.
  - SCAN (1 cycle per probe):
    - If mask[idx]=1 (hit): write idx to the dest register; clear mask[idx]. If the mask becomes 0, load 7'h7F instead (bag refill in the same cycle).
    - After a hit: if dest=CUR then dest<=NEXT, goto LOAD; else goto READY.
    - Else (miss): idx <= (idx==6) ? 0 : idx+1; stay in SCAN.
    - At most 7 probes per draw; a hit is guaranteed because the mask is never 0 when in SCAN.
  - READY: o_ready=1.
    - On i_spawn_req: cur<=next; dest<=NEXT; goto LOAD. o_ready drops the following cycle.
- Draw latency: 1 (LOAD) + 1..7 (SCAN) cycles. A spawn accepted at edge T updates o_cur_shape at T+1; o_next_shape and o_ready=1 return between T+3 and T+9.
- i_spawn_req when o_ready=0: ignored and not queued.
- i_start in any non-IDLE state (game restart):
  - mask<=7'h7F, o_cur_shape<=7, o_next_shape<=7, dest<=CUR, goto LOAD.
  - i_start has priority over i_spawn_req in the same cycle.
  - The LFSR is not reset.
- Shape 7 is never dealt. Each dealt value is unique within a bag.
- o_bag_left = popcount(mask), combinational from the registered mask. After the initial fill it reads 5.
- Dealt order is the sequence of SCAN hits. Hits 1..7 after a start are a permutation of 0..6, as are hits 8..14.

Test Plan:
- Reset: hold i_rst_n=0 for 3 cycles with i_start=1 -> o_ready=0, o_cur_shape=7, o_next_shape=7, o_bag_left=7. Release with all inputs 0 -> state remains IDLE for 20 cycles.
- Start: pulse i_start -> o_ready=1 within 16 cycles; o_cur_shape and o_next_shape in 0..6 and distinct; o_bag_left=5.
- Bag property: start, then 12 spawns, each issued the cycle after o_ready=1; log the dealt (hit) sequence -> entries 1..7 and 8..14 are each a permutation of {0..6}. o_bag_left follows 5,4,3,2,1,7(refill),6,...
- Spawn timing: spawn at edge T -> o_cur_shape equals the previous o_next_shape at T+1; o_ready=0 at T+1; o_ready=1 by T+9. Repeat i_spawn_req during the not-ready window -> no additional draw, and o_bag_left decrements by exactly 1.
- Restart: i_start while in READY, and separately in the middle of SCAN -> next cycle o_cur_shape=7 and o_next_shape=7; then a fresh pair arrives and o_bag_left=5.
- Reset mid-operation: drive i_rst_n=0 during SCAN -> next cycle all outputs equal their reset values; no write to cur/next occurs. Also check that LFSR_SEED=0 builds and deals normally.
